pc_control: RTL

PC_CONTROL -- requirements
Module: pc_control

---
 rtl/pc_control_pkg.sv | 37 +++
 rtl/pc_control_branch_cond.sv | 35 +++
 rtl/pc_control_cla16.sv | 56 +++++
 rtl/pc_control.sv | 115 +++++++++++
 4 files changed

// File: rtl/pc_control_pkg.sv
// ----------------------------------------------------------------------------
// pc_control_pkg
// Shared ISA constants for the program-counter control slice:
//   - opcode values for the control-flow instructions (B, BR, PCS, HLT)
//   - ccc condition-code encodings used by B and BR
//   - state encoding of the PC controller
//   - helper that turns the 9-bit branch immediate into a byte offset
// ----------------------------------------------------------------------------
package pc_control_pkg;

  // Opcodes, instr[15:12]
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Condition codes, instr[11:9]
  localparam logic [2:0] CCC_NE  = 3'b000;  // Z=0
  localparam logic [2:0] CCC_EQ  = 3'b001;  // Z=1
  localparam logic [2:0] CCC_GT  = 3'b010;  // Z=0 and N=0
  localparam logic [2:0] CCC_LT  = 3'b011;  // N=1
  localparam logic [2:0] CCC_GE  = 3'b100;  // Z=1 or (Z=0 and N=0)
  localparam logic [2:0] CCC_LE  = 3'b101;  // N=1 or Z=1
  localparam logic [2:0] CCC_OV  = 3'b110;  // V=1
  localparam logic [2:0] CCC_UNC = 3'b111;  // always

  // Controller states
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // instr[8:0] is a signed word offset; the PC is byte addressed, so the
  // offset is sign-extended to 16 bits and doubled.
  function automatic logic [15:0] br_byte_offset(input logic [8:0] imm);
    return {{6{imm[8]}}, imm, 1'b0};
  endfunction

endpackage

// File: rtl/pc_control_branch_cond.sv
// ----------------------------------------------------------------------------
// branch_cond
// Combinational evaluation of the 3-bit ccc condition against the ALU flags.
// Ports:
//   ccc   : condition code from instr[11:9]
//   N,Z,V : registered ALU flags
//   taken : 1 when the condition holds (opcode qualification is done by
//           the caller)
// ----------------------------------------------------------------------------
module branch_cond
  import pc_control_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       N,
  input  logic       Z,
  input  logic       V,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (ccc)
      CCC_NE:  taken = ~Z;
      CCC_EQ:  taken = Z;
      CCC_GT:  taken = ~Z & ~N;
      CCC_LT:  taken = N;
      CCC_GE:  taken = Z | (~Z & ~N);
      CCC_LE:  taken = N | Z;
      CCC_OV:  taken = V;
      CCC_UNC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control_cla16.sv
// ----------------------------------------------------------------------------
// cla16
// 16-bit carry-lookahead adder: four 4-bit lookahead groups whose group
// generate/propagate terms feed a second-level lookahead for the group
// carries. Purely combinational; carry-out is not produced because every
// user works modulo 2^16.
// Ports:
//   i_a, i_b  : 16-bit operands
//   i_cin     : carry into bit 0
//   o_sum     : (i_a + i_b + i_cin) mod 2^16
// ----------------------------------------------------------------------------
module cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum
);

  logic [15:0] w_g;   // bit generate
  logic [15:0] w_p;   // bit propagate
  logic [15:0] w_c;   // carry into each bit
  logic [2:0]  w_bg;  // group generate (top group's is never needed)
  logic [2:0]  w_bp;  // group propagate
  logic [3:0]  w_bc;  // carry into each group

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Second-level lookahead: carries into groups 1..3 straight from cin.
  assign w_bc[0] = i_cin;
  assign w_bc[1] = w_bg[0] | (w_bp[0] & i_cin);
  assign w_bc[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & i_cin);
  assign w_bc[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0]) |
                   (w_bp[2] & w_bp[1] & w_bp[0] & i_cin);

  for (genvar k = 0; k < 3; k++) begin : g_grp_gp
    localparam int B = 4 * k;
    assign w_bg[k] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) |
                     (w_p[B+3] & w_p[B+2] & w_g[B+1]) |
                     (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_bp[k] = &w_p[B+3:B];
  end

  // First-level lookahead inside each group from that group's carry-in.
  for (genvar k = 0; k < 4; k++) begin : g_grp_c
    localparam int B = 4 * k;
    assign w_c[B]   = w_bc[k];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_bc[k]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_bc[k]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B]) |
                      (w_p[B+2] & w_p[B+1] & w_p[B] & w_bc[k]);
  end

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/pc_control.sv
// ----------------------------------------------------------------------------
// pc_control
// Program-counter controller with a RUN/HALT state machine, conditional
// PC-relative (B) and register (BR) branches, HLT, and a saturating count of
// taken branches.
// Parameters:
//   RESET_PC : PC loaded on reset
//   CNT_W    : width of the taken-branch counter
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold PC, state and counter this cycle
//   instr             : instruction at the current PC
//   N_Flag/Z_Flag/V_Flag : registered ALU flags
//   reg_target        : rs value, used as BR target
//   pc, pc_plus2      : current PC and PC+2 (PCS write-back value)
//   branch_taken      : combinational, current B/BR is taken and not halted
//   halted            : registered, 1 in HALT (this is the exposed FSM state)
//   taken_cnt         : saturating taken-branch count
// ----------------------------------------------------------------------------
module pc_control
  import pc_control_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [15:0]      instr,
  input  logic             N_Flag,
  input  logic             Z_Flag,
  input  logic             V_Flag,
  input  logic [15:0]      reg_target,
  output logic [15:0]      pc,
  output logic [15:0]      pc_plus2,
  output logic             branch_taken,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [15:0]      r_pc;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [3:0]  w_opcode;
  logic        w_cond;
  logic        w_is_b;
  logic        w_is_br;
  logic        w_run;
  logic        w_taken;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_b_target;
  logic [15:0] w_next_pc;

  assign w_opcode = instr[15:12];
  assign w_is_b   = (w_opcode == OP_B);
  assign w_is_br  = (w_opcode == OP_BR);
  assign w_run    = (r_state == ST_RUN);

  branch_cond u_cond (
    .ccc   (instr[11:9]),
    .N     (N_Flag),
    .Z     (Z_Flag),
    .V     (V_Flag),
    .taken (w_cond)
  );

  cla16 u_add_pc2 (
    .i_a   (r_pc),
    .i_b   (16'd2),
    .i_cin (1'b0),
    .o_sum (w_pc_plus2)
  );

  // B target is relative to the already-incremented PC.
  cla16 u_add_tgt (
    .i_a   (w_pc_plus2),
    .i_b   (br_byte_offset(instr[8:0])),
    .i_cin (1'b0),
    .o_sum (w_b_target)
  );

  assign w_taken = (w_is_b | w_is_br) & w_cond & w_run;

  always_comb begin
    w_next_pc = w_pc_plus2;
    if (w_taken && w_is_b)       w_next_pc = w_b_target;
    else if (w_taken && w_is_br) w_next_pc = reg_target;
  end

  // Priority: rst, then stall/HALT (hold everything), then HLT, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_state     <= ST_RUN;
      r_taken_cnt <= '0;
    end else if (!stall && w_run) begin
      if (w_opcode == OP_HLT) begin
        r_state <= ST_HALT;
      end else begin
        r_pc <= w_next_pc;
        if (w_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
          r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign pc           = r_pc;
  assign pc_plus2     = w_pc_plus2;
  assign branch_taken = w_taken;
  assign halted       = (r_state == ST_HALT);
  assign taken_cnt    = r_taken_cnt;

endmodule
